// File: rtl/audio_pkg.sv
// Shared types and constants for the audio stream player.
package audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_PLAY,
        ST_REQ,
        ST_WAIT
    } player_state_t;

    localparam int UNDERRUN_W = 16;

    // Offset-binary silence level: 2^(width-1).
    function automatic logic [31:0] silence_level(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/audio_pwm_dac.sv
// Single-bit PWM DAC: free-running period counter, duty reloaded only at the
// period boundary so a new sample never truncates or stretches a pulse.
module audio_pwm_dac
    import audio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] sample,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0] MIDPOINT = WIDTH'(silence_level(WIDTH));

    logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_out_q, pwm_out_d;

    // Next-state: count, latch duty on the last count of a period, compare.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        duty_d    = (pwm_cnt_q == '1) ? sample : duty_q;
        pwm_out_d = (pwm_cnt_q < duty_q);
    end

    // Register counter, duty and output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pwm_cnt_q <= '0;
            duty_q    <= MIDPOINT;
            pwm_out_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;

endmodule

// File: rtl/audio_stream_player.sv
// Audio stream player: paces FIFO reads at the sample rate, primes before
// playback, plays silence and re-primes on underrun, drives a PWM DAC.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | not playing, output at silence
// PRIME | waiting for FIFO fill >= PRIME_LEVEL, output at silence
// PLAY  | holding current sample, waiting for the next sample tick
// REQ   | one-cycle FIFO read strobe
// WAIT  | capture read data; missing data counts as an underrun
module audio_stream_player
    import audio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SAMPLE_DIV  = 1500,
    parameter int FILL_WIDTH  = 11,
    parameter int PRIME_LEVEL = 256
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [WIDTH-1:0]      fifo_rd_data,
    input  logic                  fifo_rd_valid,
    input  logic                  fifo_empty,
    input  logic [FILL_WIDTH-1:0] fifo_fill_level,
    output logic                  pwm_out,
    output logic                  playing,
    output logic [15:0]           underrun_count
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [WIDTH-1:0]      MIDPOINT   = WIDTH'(silence_level(WIDTH));
    localparam logic [DIV_W-1:0]      TICK_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [FILL_WIDTH-1:0] PRIME_FILL = FILL_WIDTH'(PRIME_LEVEL);

    player_state_t         state_q, state_d;
    logic [DIV_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [WIDTH-1:0]      sample_next_q, sample_next_d;
    logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
    logic                  rd_en_q, rd_en_d;
    logic                  playing_q, playing_d;
    logic                  tick;
    logic                  underrun_evt;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Next-state logic for the divider, FSM, sample and underrun counter.
    always_comb begin
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        state_d       = state_q;
        sample_next_d = sample_next_q;
        underrun_d    = underrun_q;
        underrun_evt  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sample_next_d = MIDPOINT;
                if (enable) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                sample_next_d = MIDPOINT;
                if (!enable)                         state_d = ST_IDLE;
                else if (fifo_fill_level >= PRIME_FILL) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!enable) begin
                    state_d       = ST_IDLE;
                    sample_next_d = MIDPOINT;
                end else if (tick) begin
                    if (!fifo_empty) begin
                        state_d = ST_REQ;
                    end else begin
                        underrun_evt = 1'b1;
                        state_d      = ST_PRIME;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fifo_rd_valid) begin
                    sample_next_d = fifo_rd_data;
                    state_d       = ST_PLAY;
                end else begin
                    underrun_evt = 1'b1;
                    state_d      = ST_PRIME;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (underrun_evt) begin
            sample_next_d = MIDPOINT;
            if (underrun_q != '1) underrun_d = underrun_q + 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        rd_en_d   = (state_d == ST_REQ);
        playing_d = (state_d == ST_PLAY) || (state_d == ST_REQ) || (state_d == ST_WAIT);
    end

    // State and output registers; reset drops any read in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            sample_next_q <= MIDPOINT;
            underrun_q    <= '0;
            rd_en_q       <= 1'b0;
            playing_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            sample_next_q <= sample_next_d;
            underrun_q    <= underrun_d;
            rd_en_q       <= rd_en_d;
            playing_q     <= playing_d;
        end
    end

    assign fifo_rd_en     = rd_en_q;
    assign playing        = playing_q;
    assign underrun_count = underrun_q;

    audio_pwm_dac #(
        .WIDTH (WIDTH)
    ) u_pwm_dac (
        .CLK     (CLK),
        .RESET   (RESET),
        .sample  (sample_next_q),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_audio_stream_player.sv
// Bench for audio_stream_player with a behavioural FIFO attached.
module tb_audio_stream_player;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_valid = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [10:0] fifo_fill_level = 11'd0;
    logic        pwm_out;
    logic        playing;
    logic [15:0] underrun_count;

    audio_stream_player #(
        .WIDTH       (8),
        .SAMPLE_DIV  (16),
        .FILL_WIDTH  (11),
        .PRIME_LEVEL (4)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .enable          (enable),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_valid   (fifo_rd_valid),
        .fifo_empty      (fifo_empty),
        .fifo_fill_level (fifo_fill_level),
        .pwm_out         (pwm_out),
        .playing         (playing),
        .underrun_count  (underrun_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    int  duties[$];
    int  cyc = 0;
    int  win_hi = 0;
    int  nreads = 0;
    int  last_rd = 0;
    bit  pend = 0;
    bit  ov_en = 0;
    bit  ov_empty = 0;
    int  ov_fill = 0;

    typedef struct {
        logic [7:0] data;
        int         exp_hi;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic update_flags();
        fifo_empty      = ov_en ? ov_empty : (q.size() == 0);
        fifo_fill_level = ov_en ? 11'(ov_fill) : 11'(q.size());
    endtask

    // One clock: FIFO model, PWM window accounting, read-strobe checks.
    task automatic step();
        bit rst_e;
        bit empty_at_tick;
        rst_e         = RESET;
        empty_at_tick = fifo_empty;
        @(posedge CLK);
        #1;
        if (rst_e) begin
            cyc           = 0;
            win_hi        = 0;
            pend          = 0;
            fifo_rd_valid = 1'b0;
        end else begin
            cyc++;
            if (pend && q.size() > 0) begin
                fifo_rd_data  = q.pop_front();
                fifo_rd_valid = 1'b1;
            end else begin
                fifo_rd_valid = 1'b0;
            end
            pend = 0;
            win_hi += int'(pwm_out);
            if (cyc % 256 == 0) begin
                duties.push_back(win_hi);
                win_hi = 0;
            end
        end
        if (fifo_rd_en) begin
            nreads++;
            last_rd = cyc;
            pend    = !ov_en;
            chk("rd_on_tick_slot", cyc % 16, 0);
            chk("rd_not_when_empty", int'(empty_at_tick), 0);
        end
        update_flags();
    endtask

    task automatic do_reset();
        RESET  = 1'b1;
        enable = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        duties.delete();
        nreads = 0;
    endtask

    task automatic run_until_rd(input int maxc, output bit ok);
        int n0;
        n0 = nreads;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (nreads != n0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_windows(input int n, input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            if (duties.size() >= n) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [7:0] steady[3];
        bit ok;
        int n;
        int m;
        int prev_rd;

        vecs[0] = '{data: 8'h00, exp_hi: 0};
        vecs[1] = '{data: 8'hFF, exp_hi: 255};
        vecs[2] = '{data: 8'h40, exp_hi: 64};
        vecs[3] = '{data: 8'h01, exp_hi: 1};
        vecs[4] = '{data: 8'hC3, exp_hi: 195};
        steady[0] = 8'h00;
        steady[1] = 8'hFF;
        steady[2] = 8'h40;

        // Reset state and idle silence.
        update_flags();
        do_reset();
        chk("reset_pwm_out", int'(pwm_out), 0);
        chk("reset_rd_en", int'(fifo_rd_en), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_underrun", underrun_count, 0);
        repeat (512) step();
        chk("idle_windows", duties.size(), 2);
        if (duties.size() >= 2) begin
            chk("idle_duty0", duties[0], 128);
            chk("idle_duty1", duties[1], 128);
        end

        // Prime: 3 samples hold in PRIME, the 4th starts playback.
        do_reset();
        q = '{8'h11, 8'h22, 8'h33};
        update_flags();
        enable = 1'b1;
        repeat (40) step();
        chk("prime_no_reads", nreads, 0);
        chk("prime_not_playing", int'(playing), 0);
        while (cyc % 16 != 4) step();
        n = cyc;
        q.push_back(8'h44);
        update_flags();
        step();
        chk("prime_to_play", int'(playing), 1);
        chk("prime_no_same_cycle_rd", int'(fifo_rd_en), 0);
        run_until_rd(32, ok);
        chk("first_rd_seen", int'(ok), 1);
        chk("first_rd_cycle", last_rd, n + 12);

        // Underrun after the 4 samples drain, then refill resumes.
        for (int i = 0; i < 200 && cyc < n + 76; i++) step();
        chk("underrun_cycle_reached", cyc, n + 76);
        chk("underrun_playing", int'(playing), 0);
        chk("underrun_count_1", underrun_count, 1);
        chk("underrun_no_rd", int'(fifo_rd_en), 0);
        chk("underrun_reads", nreads, 4);
        m = duties.size();
        wait_windows(m + 2, 700, ok);
        chk("underrun_window_seen", int'(ok), 1);
        if (ok) chk("underrun_duty_mid", duties[duties.size() - 1], 128);
        chk("underrun_still_1", underrun_count, 1);
        q = '{8'h10, 8'h20, 8'h30, 8'h40};
        update_flags();
        run_until_rd(64, ok);
        chk("refill_resumes", int'(ok), 1);
        chk("refill_playing", int'(playing), 1);

        // Steady play: reads 16 cycles apart, each sample captured in order.
        do_reset();
        q = '{8'h00, 8'hFF, 8'h40, 8'h80};
        update_flags();
        enable = 1'b1;
        prev_rd = 0;
        for (int k = 0; k < 3; k++) begin
            run_until_rd(64, ok);
            chk("steady_rd_seen", int'(ok), 1);
            if (k > 0) chk("steady_rd_spacing", last_rd - prev_rd, 16);
            prev_rd = last_rd;
            step();
            step();
            chk("steady_sample", dut.sample_next_q, steady[k]);
        end

        // Table: sustained sample value gives that many high cycles per period.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            q.delete();
            for (int i = 0; i < 40; i++) q.push_back(vecs[v].data);
            update_flags();
            enable = 1'b1;
            run_until_rd(64, ok);
            chk("vec_rd_seen", int'(ok), 1);
            step();
            step();
            m = duties.size();
            wait_windows(m + 2, 700, ok);
            chk("vec_window_seen", int'(ok), 1);
            if (ok) chk("vec_duty", duties[duties.size() - 1], vecs[v].exp_hi);
        end

        // enable dropped in REQ: read completes, sample kept, then IDLE.
        do_reset();
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'h5A);
        update_flags();
        enable = 1'b1;
        run_until_rd(64, ok);
        chk("drop_rd_seen", int'(ok), 1);
        enable = 1'b0;
        step();
        chk("drop_wait_playing", int'(playing), 1);
        step();
        chk("drop_play_playing", int'(playing), 1);
        chk("drop_sample_kept", dut.sample_next_q, 8'h5A);
        step();
        chk("drop_idle", int'(playing), 0);
        n = nreads;
        repeat (64) step();
        chk("drop_no_more_reads", nreads - n, 0);
        chk("drop_fifo_left", q.size(), 5);

        // Reset during WAIT: the arriving data is discarded.
        do_reset();
        q = '{8'h10, 8'h10, 8'h10, 8'h10};
        update_flags();
        enable = 1'b1;
        run_until_rd(64, ok);
        chk("midrst_rd_seen", int'(ok), 1);
        step();
        chk("midrst_valid_arrives", int'(fifo_rd_valid), 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("midrst_playing", int'(playing), 0);
        chk("midrst_rd_en", int'(fifo_rd_en), 0);
        chk("midrst_sample_mid", dut.sample_next_q, 8'h80);
        n = nreads;
        repeat (300) step();
        chk("midrst_no_reads", nreads - n, 0);
        chk("midrst_still_prime", int'(playing), 0);

        // Saturation: preload near full scale, then keep underrunning.
        do_reset();
        ov_en    = 1;
        ov_fill  = 4;
        ov_empty = 1;
        update_flags();
        enable = 1'b1;
        step();
        force dut.underrun_q = 16'hFFFD;
        step();
        step();
        release dut.underrun_q;
        repeat (96) step();
        chk("sat_underrun", underrun_count, 16'hFFFF);
        chk("sat_no_reads", nreads, 0);
        ov_en  = 0;
        enable = 1'b0;
        update_flags();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
